// File: rtl/wrapping_count_unwrapper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wrapping_count_unwrapper_pkg
// Description : Shared types for the wrapping-count unwrapper. Provides the
//               classification of an observed sample against the last
//               accepted count.
// Revision    : 1.0 - initial release
// ============================================================================
package wrapping_count_unwrapper_pkg;

    // Result of comparing a sampled count against the reference value.
    typedef enum logic [2:0] {
        CLS_IDLE  = 3'd0,   // no sample this cycle
        CLS_EQUAL = 3'd1,   // same value, no step
        CLS_INC   = 3'd2,   // +1 step (modulo RANGE)
        CLS_DEC   = 3'd3,   // -1 step (modulo RANGE)
        CLS_JUMP  = 3'd4,   // illegal multi-step jump
        CLS_RANGE = 3'd5    // value outside 0..RANGE-1
    } step_class_t;

endpackage
`default_nettype wire

// File: rtl/wrapping_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrapping_counter
// Description : Modulo-RANGE up/down counter. Simultaneous increment and
//               decrement cancel out. Power-of-two ranges use natural
//               overflow; other ranges wrap explicitly at RANGE-1 / 0.
// Ports       : clock      - rising-edge clock
//               resetn     - asynchronous active-low reset
//               increment  - count +1 (wraps RANGE-1 -> 0)
//               decrement  - count -1 (wraps 0 -> RANGE-1)
//               count      - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module wrapping_counter #(
    parameter int RANGE       = 4,
    parameter int WIDTH       = (RANGE > 1) ? $clog2(RANGE) : 1,
    parameter int RESET_VALUE = 0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             increment,
    input  logic             decrement,
    output logic [WIDTH-1:0] count
);

    localparam bit               C_FULL = ((1 << WIDTH) == RANGE);
    localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(RANGE - 1);

    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_prev;

    generate
        if (C_FULL) begin : g_pow2
            assign w_next = count + 1'b1;
            assign w_prev = count - 1'b1;
        end else begin : g_npow2
            assign w_next = (count == C_MAX) ? '0 : count + 1'b1;
            assign w_prev = (count == '0) ? C_MAX : count - 1'b1;
        end
    endgenerate

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= WIDTH'(RESET_VALUE);
        end else if (increment && !decrement) begin
            count <= w_next;
        end else if (decrement && !increment) begin
            count <= w_prev;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wrapping_count_unwrapper.sv
`default_nettype none
// ============================================================================
// Module      : wrapping_count_unwrapper
// Description : Follows a wrapped count sampled from a remote wrapping
//               counter, emits +1/-1 step and wrap pulses, keeps a lap count
//               and an unwrapped extended count. Illegal jumps resynchronise
//               the reference value.
// Ports       : clock          - rising-edge clock
//               resetn         - asynchronous active-low reset
//               count_valid    - count is sampled this cycle
//               count          - observed wrapped count
//               error_clear    - clears the sticky error flag
//               step_increment - one-cycle pulse on a +1 step
//               step_decrement - one-cycle pulse on a -1 step
//               wrapped        - one-cycle pulse on a wrap in either direction
//               laps           - signed-modulo lap count
//               extended       - unwrapped count
//               error          - sticky illegal-jump / out-of-range flag
// Config      : WRAPPING_COUNT_UNWRAPPER_ERROR_EN enables jump/range checking
//               and the error flag; otherwise error is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module wrapping_count_unwrapper
    import wrapping_count_unwrapper_pkg::*;
#(
    parameter int RANGE          = 4,
    parameter int RANGE_LOG2     = (RANGE > 1) ? $clog2(RANGE) : 1,
    parameter int LAP_WIDTH      = 8,
    parameter int EXTENDED_WIDTH = 16,
    parameter int RESET_VALUE    = 0
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      count_valid,
    input  logic [RANGE_LOG2-1:0]     count,
    input  logic                      error_clear,
    output logic                      step_increment,
    output logic                      step_decrement,
    output logic                      wrapped,
    output logic [LAP_WIDTH-1:0]      laps,
    output logic [EXTENDED_WIDTH-1:0] extended,
    output logic                      error
);

    // Range check is needed whenever the count field can encode values that
    // the remote counter never produces (non-pow2 RANGE, and RANGE==1).
    localparam bit                    C_FULL  = ((1 << RANGE_LOG2) == RANGE);
    localparam logic [RANGE_LOG2-1:0] C_MAX   = RANGE_LOG2'(RANGE - 1);
    localparam logic [RANGE_LOG2-1:0] C_RESET = RANGE_LOG2'(RESET_VALUE);

    function automatic logic [RANGE_LOG2-1:0] next_val(input logic [RANGE_LOG2-1:0] v);
        if (C_FULL) return v + 1'b1;
        else        return (v == C_MAX) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [RANGE_LOG2-1:0] prev_val(input logic [RANGE_LOG2-1:0] v);
        if (C_FULL) return v - 1'b1;
        else        return (v == '0) ? C_MAX : v - 1'b1;
    endfunction

    logic [RANGE_LOG2-1:0] r_last;
    logic                  w_in_range;
    step_class_t           w_class;
    logic                  w_inc;
    logic                  w_dec;
    logic                  w_lap_up;
    logic                  w_lap_dn;

    assign w_in_range = C_FULL ? 1'b1 : (count <= C_MAX);

    // Increment is tested before decrement so RANGE==2 resolves to +1.
    always_comb begin
        w_class = CLS_IDLE;
        if (count_valid) begin
            if (!w_in_range)                      w_class = CLS_RANGE;
            else if (count == r_last)             w_class = CLS_EQUAL;
            else if (count == next_val(r_last))   w_class = CLS_INC;
            else if (count == prev_val(r_last))   w_class = CLS_DEC;
            else                                  w_class = CLS_JUMP;
        end
    end

    assign w_inc    = (w_class == CLS_INC);
    assign w_dec    = (w_class == CLS_DEC);
    assign w_lap_up = w_inc && (r_last == C_MAX);
    assign w_lap_dn = w_dec && (r_last == '0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_last         <= C_RESET;
            step_increment <= 1'b0;
            step_decrement <= 1'b0;
            wrapped        <= 1'b0;
            extended       <= EXTENDED_WIDTH'(RESET_VALUE);
        end else begin
            step_increment <= w_inc;
            step_decrement <= w_dec;
            wrapped        <= w_lap_up || w_lap_dn;
            // Every in-range sample becomes the new reference, which also
            // resynchronises after an illegal jump.
            if (count_valid && w_in_range) begin
                r_last <= count;
            end
            if (w_inc) begin
                extended <= extended + 1'b1;
            end else if (w_dec) begin
                extended <= extended - 1'b1;
            end
        end
    end

    wrapping_counter #(
        .RANGE       (2 ** LAP_WIDTH),
        .WIDTH       (LAP_WIDTH),
        .RESET_VALUE (0)
    ) u_laps (
        .clock     (clock),
        .resetn    (resetn),
        .increment (w_lap_up),
        .decrement (w_lap_dn),
        .count     (laps)
    );

`ifdef WRAPPING_COUNT_UNWRAPPER_ERROR_EN
    logic w_err_event;
    assign w_err_event = (w_class == CLS_JUMP) || (w_class == CLS_RANGE);

    // A new error wins over a simultaneous clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            error <= 1'b0;
        end else if (w_err_event) begin
            error <= 1'b1;
        end else if (error_clear) begin
            error <= 1'b0;
        end
    end
`else
    logic w_unused_error_clear;
    assign w_unused_error_clear = error_clear;
    assign error                = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wrapping_count_unwrapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_wrapping_count_unwrapper
// Description : Self-checking bench. Three DUT instances (RANGE 4, 5, 2)
//               share one count bus (truncated per instance) and one
//               error_clear; each has its own count_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wrapping_count_unwrapper;

`ifdef WRAPPING_COUNT_UNWRAPPER_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic [2:0]  vld;
    logic [2:0]  cnt;
    logic        clr;

    logic        inc_o  [3];
    logic        dec_o  [3];
    logic        wrp_o  [3];
    logic [7:0]  laps_o [3];
    logic [15:0] ext_o  [3];
    logic        err_o  [3];

    int nchk = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    wrapping_count_unwrapper #(.RANGE(4)) u_r4 (
        .clock(clock), .resetn(resetn), .count_valid(vld[0]), .count(cnt[1:0]),
        .error_clear(clr), .step_increment(inc_o[0]), .step_decrement(dec_o[0]),
        .wrapped(wrp_o[0]), .laps(laps_o[0]), .extended(ext_o[0]), .error(err_o[0]));

    wrapping_count_unwrapper #(.RANGE(5)) u_r5 (
        .clock(clock), .resetn(resetn), .count_valid(vld[1]), .count(cnt[2:0]),
        .error_clear(clr), .step_increment(inc_o[1]), .step_decrement(dec_o[1]),
        .wrapped(wrp_o[1]), .laps(laps_o[1]), .extended(ext_o[1]), .error(err_o[1]));

    wrapping_count_unwrapper #(.RANGE(2)) u_r2 (
        .clock(clock), .resetn(resetn), .count_valid(vld[2]), .count(cnt[0:0]),
        .error_clear(clr), .step_increment(inc_o[2]), .step_decrement(dec_o[2]),
        .wrapped(wrp_o[2]), .laps(laps_o[2]), .extended(ext_o[2]), .error(err_o[2]));

    // ---------------- reference model (plain modular arithmetic) ----------
    int m_last [3];
    int m_laps [3];
    int m_ext  [3];
    bit m_err  [3];
    bit m_inc  [3];
    bit m_dec  [3];
    bit m_wrp  [3];

    function automatic int rng(input int i);
        return (i == 0) ? 4 : (i == 1) ? 5 : 2;
    endfunction

    function automatic int view(input int i, input logic [2:0] c);
        return (i == 0) ? int'(c[1:0]) : (i == 1) ? int'(c) : int'(c[0]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_last[i] = 0; m_laps[i] = 0; m_ext[i] = 0;
            m_err[i] = 0; m_inc[i] = 0; m_dec[i] = 0; m_wrp[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit v, input int c, input bit cl);
        int r;
        bit evt;
        r = rng(i);
        evt = 0;
        m_inc[i] = 0; m_dec[i] = 0; m_wrp[i] = 0;
        if (v) begin
            if (c >= r) begin
                evt = 1;
            end else begin
                if (c == m_last[i]) begin
                end else if (c == (m_last[i] + 1) % r) begin
                    m_inc[i] = 1;
                    m_ext[i] = (m_ext[i] + 1) % 65536;
                    if (m_last[i] == r - 1) begin
                        m_laps[i] = (m_laps[i] + 1) % 256;
                        m_wrp[i]  = 1;
                    end
                end else if (c == (m_last[i] + r - 1) % r) begin
                    m_dec[i] = 1;
                    m_ext[i] = (m_ext[i] + 65535) % 65536;
                    if (m_last[i] == 0) begin
                        m_laps[i] = (m_laps[i] + 255) % 256;
                        m_wrp[i]  = 1;
                    end
                end else begin
                    evt = 1;
                end
                m_last[i] = c;
            end
        end
        if (evt && ERR_EN) m_err[i] = 1;
        else if (cl)       m_err[i] = 0;
    endtask

    // ---------------- checking helpers ------------------------------------
    function automatic logic [27:0] pk(input bit i_inc, input bit i_dec, input bit i_wrp,
                                       input logic [7:0] l, input logic [15:0] e, input bit er);
        return {i_inc, i_dec, i_wrp, l, e, er};
    endfunction

    function automatic logic [27:0] act(input int i);
        return {inc_o[i], dec_o[i], wrp_o[i], laps_o[i], ext_o[i], err_o[i]};
    endfunction

    task automatic check(input int i, input string name, input logic [27:0] exp);
        logic [27:0] a;
        a = act(i);
        nchk++;
        if (a !== exp) begin
            nerr++;
            $display("FAIL %s inst%0d: got inc=%b dec=%b wrp=%b laps=%h ext=%h err=%b, want inc=%b dec=%b wrp=%b laps=%h ext=%h err=%b",
                     name, i, a[27], a[26], a[25], a[24:17], a[16:1], a[0],
                     exp[27], exp[26], exp[25], exp[24:17], exp[16:1], exp[0]);
        end
    endtask

    task automatic check_model(input int i, input string name);
        check(i, name, pk(m_inc[i], m_dec[i], m_wrp[i], 8'(m_laps[i]), 16'(m_ext[i]), m_err[i]));
    endtask

    task automatic drive(input logic [2:0] vm, input logic [2:0] c, input bit cl);
        vld = vm; cnt = c; clr = cl;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) model_step(i, vm[i], view(i, c), cl);
    endtask

    task automatic do_reset();
        resetn = 1'b0; vld = '0; cnt = '0; clr = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) check(i, "reset_state", pk(0, 0, 0, 8'h00, 16'h0000, 0));
        resetn = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vectors ------------------------------------
    typedef struct {
        int          inst;
        bit          v;
        logic [2:0]  c;
        bit          inc;
        bit          dec;
        bit          wrp;
        logic [7:0]  laps;
        logic [15:0] ext;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [2:0] pc;
        logic [2:0] vm;
        bit         cl;
        int         r;

        tbl[0]  = '{0, 1, 3'd1, 1, 0, 0, 8'h00, 16'd1};
        tbl[1]  = '{0, 1, 3'd2, 1, 0, 0, 8'h00, 16'd2};
        tbl[2]  = '{0, 1, 3'd3, 1, 0, 0, 8'h00, 16'd3};
        tbl[3]  = '{0, 1, 3'd0, 1, 0, 1, 8'h01, 16'd4};
        tbl[4]  = '{0, 1, 3'd1, 1, 0, 0, 8'h01, 16'd5};
        tbl[5]  = '{0, 0, 3'd2, 0, 0, 0, 8'h01, 16'd5};
        tbl[6]  = '{1, 1, 3'd4, 0, 1, 1, 8'hFF, 16'hFFFF};
        tbl[7]  = '{1, 1, 3'd3, 0, 1, 0, 8'hFF, 16'hFFFE};
        tbl[8]  = '{2, 1, 3'd1, 1, 0, 0, 8'h00, 16'd1};
        tbl[9]  = '{2, 1, 3'd0, 1, 0, 1, 8'h01, 16'd2};
        tbl[10] = '{2, 1, 3'd1, 1, 0, 0, 8'h01, 16'd3};

        do_reset();
        for (int k = 0; k < 11; k++) begin
            drive(tbl[k].v ? 3'(1 << tbl[k].inst) : 3'b000, tbl[k].c, 1'b0);
            check(tbl[k].inst, "table",
                  pk(tbl[k].inc, tbl[k].dec, tbl[k].wrp, tbl[k].laps, tbl[k].ext, 1'b0));
        end

        // Jump, out-of-range and error_clear priority on the RANGE=5 instance.
        do_reset();
        drive(3'b010, 3'd0, 1'b0); check(1, "equal_sample",  pk(0, 0, 0, 8'h00, 16'd0, 0));
        drive(3'b010, 3'd2, 1'b0); check(1, "jump_0_to_2",   pk(0, 0, 0, 8'h00, 16'd0, ERR_EN));
        drive(3'b010, 3'd3, 1'b0); check(1, "resync_inc",    pk(1, 0, 0, 8'h00, 16'd1, ERR_EN));
        drive(3'b000, 3'd0, 1'b1); check(1, "clear_alone_1", pk(0, 0, 0, 8'h00, 16'd1, 0));
        drive(3'b010, 3'd7, 1'b0); check(1, "out_of_range",  pk(0, 0, 0, 8'h00, 16'd1, ERR_EN));
        drive(3'b010, 3'd6, 1'b1); check(1, "err_beats_clr", pk(0, 0, 0, 8'h00, 16'd1, ERR_EN));
        drive(3'b000, 3'd0, 1'b1); check(1, "clear_alone_2", pk(0, 0, 0, 8'h00, 16'd1, 0));
        drive(3'b010, 3'd4, 1'b0); check(1, "last_kept",     pk(1, 0, 0, 8'h00, 16'd2, 0));

        // Asynchronous reset in the middle of a stream.
        do_reset();
        drive(3'b001, 3'd1, 1'b0);
        drive(3'b001, 3'd2, 1'b0);
        drive(3'b001, 3'd3, 1'b0); check(0, "pre_reset",   pk(1, 0, 0, 8'h00, 16'd3, 0));
        #2;
        resetn = 1'b0;
        #1;
        check(0, "async_reset", pk(0, 0, 0, 8'h00, 16'd0, 0));
        @(posedge clock);
        #1;
        resetn = 1'b1;
        model_reset();
        drive(3'b001, 3'd1, 1'b0); check(0, "after_reset", pk(1, 0, 0, 8'h00, 16'd1, 0));

        // Randomised stream against the reference model.
        do_reset();
        pc = 3'd0;
        for (int n = 0; n < 500; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)      pc = pc + 3'd1;
            else if (r < 8) pc = pc - 3'd1;
            else            pc = 3'($urandom_range(0, 7));
            vm = 3'($urandom_range(0, 7));
            cl = ($urandom_range(0, 9) == 0);
            drive(vm, pc, cl);
            for (int i = 0; i < 3; i++) check_model(i, "random");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
